doe_kv_wr_seq: RTL and testbench
================================

DOE_KV_WR_SEQ -- requirements
Module: doe_kv_wr_seq

Interface
REQ-001 SHALL have parameter MAX_DWORDS, default 16: maximum dwords written per flow.
REQ-002 SHALL have parameter ENTRY_W, default KV_ENTRY_ADDR_W: width of the key-vault slot index.
REQ-003 SHALL have port clk  input  1: the only clock; everything is on posedge clk.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port zeroize  input  1: synchronous clear of all state and data.
REQ-006 SHALL have port start  input  1: one-cycle pulse that begins a flow.
REQ-007 SHALL have port dest_entry  input  ENTRY_W: target KV slot, sampled on start.
REQ-008 SHALL have port total_dwords  input  5: dword count for the flow (1..MAX_DWORDS), sampled on start.
REQ-009 SHALL have port dest_valid  input  KV_NUM_READ: destination-valid mask, sampled on start.
REQ-010 SHALL have port blk_valid  input  1: a 128b result block from the DOE core is offered.
REQ-011 SHALL have port blk_data  input  128: result block; dword0 = [127:96].
REQ-012 SHALL have port blk_ready  output  1: the sequencer accepts a block this cycle.
REQ-013 SHALL have port kv_write  output  kv_write_t: fields write_en, write_entry, write_offset, write_data, write_dest_valid.
REQ-014 SHALL have port busy  output  1: high whenever state != IDLE.
REQ-015 SHALL have port done  output  1: one-cycle pulse when the flow completes.
REQ-016 SHALL have port error  output  1: one-cycle pulse when start carries an illegal total_dwords.

Function
REQ-017 SHALL use states IDLE, WAIT_BLK, WRITE, DONE.
REQ-018 IDLE: start with total_dwords in 1..MAX_DWORDS SHALL latch the entry, count and mask, clear the dword offset, and go to WAIT_BLK.
REQ-019 IDLE: start with total_dwords == 0 or > MAX_DWORDS SHALL pulse error the next cycle and stay IDLE.
REQ-020 start outside IDLE SHALL be ignored: no state change, no error.
REQ-021 blk_ready SHALL be high only in WAIT_BLK; a block is accepted when blk_valid & blk_ready, which latches blk_data and moves to WRITE.
REQ-022 WRITE SHALL drive one registered write per cycle:
- write_en=1
- write_entry = latched entry
- write_offset = running offset
- write_data = next dword, dword0 first
- write_dest_valid = latched mask
REQ-023 The first write_en SHALL occur the cycle after the block is accepted.
REQ-024 The offset SHALL increment by 1 per write and SHALL NOT wrap; the maximum offset is MAX_DWORDS-1.
REQ-025 After the 4th dword of a block, WRITE SHALL return to WAIT_BLK if fewer than total_dwords have been written.
REQ-026 When the written count reaches total_dwords (including mid-block), WRITE SHALL go to DONE; the unused dwords of that block are discarded.
REQ-027 DONE SHALL pulse done for one cycle, then go to IDLE; write_en SHALL be 0 in DONE.
REQ-028 write_en SHALL be 0 in every state except WRITE; when write_en=0, write_data SHALL be 0.
REQ-029 blk_valid in any state other than WAIT_BLK SHALL be ignored; the upstream holds the block.
REQ-030 zeroize SHALL take priority over all other inputs: on the next edge, state=IDLE, all latched data/offset/count=0, all outputs 0, and any in-flight write is aborted.

Reset
REQ-031 On reset_n low, state SHALL be IDLE, all registers 0, and kv_write, blk_ready, busy, done and error SHALL be 0, independent of clk.
REQ-032 Deassertion of reset_n mid-flow SHALL leave the block in IDLE, with no resumption of the aborted flow.

Structure
REQ-033 doe_defines_pkg SHALL hold the state enum (doe_kv_wr_state_e) and the constant DOE_KV_WR_MAX_DWORDS=16.
REQ-034 kv_write_t and KV_ENTRY_ADDR_W/KV_NUM_READ SHALL come from kv_defines_pkg.
REQ-035 The block SHALL be a single module with no sub-module; it sits downstream of the DOE CBC core result and upstream of the key vault write port.

Verification
REQ-036 Scenario, full UDS flow: start, entry=0, total=16, 4 blocks, blk_data=0x00112233_44556677_8899AABB_CCDDEEFF, etc. -> 16 writes at offsets 0..15, first write data 0x00112233, done at cycle after offset 15.
REQ-037 Scenario, partial block: total=6, 2 blocks -> 6 writes at offsets 0..5, dwords 2-3 of the 2nd block never written, done pulses once.
REQ-038 Scenario, illegal count: start with total=0, then total=17 -> error pulse each time, busy stays 0, no write_en.
REQ-039 Scenario, backpressure and ignored input: blk_valid held during WRITE, plus start asserted mid-flow -> blk_ready=0 until WAIT_BLK; the second start has no effect; write sequence unchanged.
REQ-040 Scenario, zeroize mid-flow: zeroize at offset 5 of a 16-dword flow -> next cycle IDLE, write_en=0, busy=0; a new start with total=4 writes from offset 0.
REQ-041 Scenario, reset mid-flow: reset_n low during WRITE -> outputs 0 asynchronously; after release, IDLE with no writes until the next start.

Source files
------------

// File: rtl/doe_defines_pkg.sv
// DOE-side definitions for the key-vault write sequencer.
package doe_defines_pkg;
  localparam int DOE_KV_WR_MAX_DWORDS = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } doe_kv_wr_state_e;
endpackage

// File: rtl/kv_defines_pkg.sv
// Key-vault shared definitions: slot geometry and the write-port bundle.
package kv_defines_pkg;
  localparam int KV_ENTRY_ADDR_W = 5;
  localparam int KV_ENTRY_SIZE_W = 4;
  localparam int KV_NUM_READ     = 6;
  localparam int KV_DATA_W       = 32;

  typedef struct packed {
    logic                       write_en;
    logic [KV_ENTRY_ADDR_W-1:0] write_entry;
    logic [KV_ENTRY_SIZE_W-1:0] write_offset;
    logic [KV_DATA_W-1:0]       write_data;
    logic [KV_NUM_READ-1:0]     write_dest_valid;
  } kv_write_t;
endpackage

// File: rtl/doe_kv_wr_seq_if.sv
// 128-bit result-block handshake from the DOE core into the KV write sequencer.
interface doe_kv_wr_seq_if;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready;

  modport master (output blk_valid, output blk_data, input  blk_ready);
  modport slave  (input  blk_valid, input  blk_data, output blk_ready);
endinterface

// File: rtl/doe_kv_wr_seq.sv
// Splits DOE result blocks into dword writes on the key-vault write port.
//   state    | meaning
//   IDLE     | waiting for start; illegal counts raise error
//   WAIT_BLK | blk_ready high, waiting for the next 128b block
//   WRITE    | one dword written per cycle from the latched block
//   DONE     | done pulse, then back to IDLE
module doe_kv_wr_seq
  import kv_defines_pkg::*;
  import doe_defines_pkg::*;
#(
  parameter int MAX_DWORDS = DOE_KV_WR_MAX_DWORDS,
  parameter int ENTRY_W    = KV_ENTRY_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   zeroize,
  input  logic                   start,
  input  logic [ENTRY_W-1:0]     dest_entry,
  input  logic [4:0]             total_dwords,
  input  logic [KV_NUM_READ-1:0] dest_valid,
  doe_kv_wr_seq_if.slave         blk,
  output kv_write_t              kv_write,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  doe_kv_wr_state_e state_q, state_nxt;

  logic [ENTRY_W-1:0]         entry_q;
  logic [4:0]                 count_q;
  logic [KV_NUM_READ-1:0]     mask_q;
  logic [KV_ENTRY_SIZE_W-1:0] offset_q;
  logic [1:0]                 idx_q;
  logic [127:0]               blk_q;
  logic                       error_q;

  logic cnt_legal, latch_cmd, accept, advance, last_dw, err_nxt;
  logic [31:0] dword_sel;

  assign cnt_legal = (total_dwords != 5'd0) && (32'(total_dwords) <= 32'(MAX_DWORDS));
  assign last_dw   = (({1'b0, offset_q} + 5'd1) == count_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    latch_cmd = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cnt_legal) begin
            latch_cmd = 1'b1;
            state_nxt = WAIT_BLK;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WAIT_BLK: begin
        if (blk.blk_valid) begin
          accept    = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // Offset is frozen on the final write so it never passes MAX_DWORDS-1.
        if (last_dw) begin
          state_nxt = DONE;
        end else begin
          advance = 1'b1;
          if (idx_q == 2'd3) state_nxt = WAIT_BLK;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (zeroize) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q  <= '0;
      count_q  <= '0;
      mask_q   <= '0;
      offset_q <= '0;
      idx_q    <= '0;
      blk_q    <= '0;
      error_q  <= 1'b0;
    end else if (zeroize) begin
      entry_q  <= '0;
      count_q  <= '0;
      mask_q   <= '0;
      offset_q <= '0;
      idx_q    <= '0;
      blk_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= err_nxt;
      if (latch_cmd) begin
        entry_q  <= dest_entry;
        count_q  <= total_dwords;
        mask_q   <= dest_valid;
        offset_q <= '0;
        idx_q    <= '0;
      end
      if (accept) blk_q <= blk.blk_data;
      if (advance) begin
        offset_q <= offset_q + 1'b1;
        idx_q    <= idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    dword_sel = blk_q[127:96];
      2'd1:    dword_sel = blk_q[95:64];
      2'd2:    dword_sel = blk_q[63:32];
      default: dword_sel = blk_q[31:0];
    endcase
  end

  always_comb begin
    kv_write = '0;
    if (state_q == WRITE) begin
      kv_write.write_en         = 1'b1;
      kv_write.write_entry      = KV_ENTRY_ADDR_W'(entry_q);
      kv_write.write_offset     = offset_q;
      kv_write.write_data       = dword_sel;
      kv_write.write_dest_valid = mask_q;
    end
  end

  assign blk.blk_ready = (state_q == WAIT_BLK);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign error         = error_q;

endmodule

// File: tb/tb_doe_kv_wr_seq.sv
// Scoreboard bench for the DOE key-vault write sequencer.
module tb_doe_kv_wr_seq;
  import kv_defines_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       zeroize = 1'b0;
  logic       start = 1'b0;
  logic [4:0] dest_entry = '0;
  logic [4:0] total_dwords = '0;
  logic [5:0] dest_valid = '0;
  kv_write_t  kv_write;
  logic       busy, done, error;

  doe_kv_wr_seq_if blk_if ();

  doe_kv_wr_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .zeroize      (zeroize),
    .start        (start),
    .dest_entry   (dest_entry),
    .total_dwords (total_dwords),
    .dest_valid   (dest_valid),
    .blk          (blk_if.slave),
    .kv_write     (kv_write),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [46:0] sb_q[$];
  int done_cnt = 0;
  int err_cnt = 0;
  logic prev_we = 1'b0;
  bit ms_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [46:0] pack_wr(input logic [4:0] e, input logic [3:0] o,
                                          input logic [5:0] m, input logic [31:0] d);
    return {e, o, m, d};
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (kv_write.write_en) begin
        chk("ready_in_wr", blk_if.blk_ready, 0);
        chk("busy_in_wr", busy, 1);
        if (sb_q.size() == 0) chk("unexp_wr_sb_size", sb_q.size(), 1);
        else chk("wr", pack_wr(kv_write.write_entry, kv_write.write_offset,
                               kv_write.write_dest_valid, kv_write.write_data),
                 sb_q.pop_front());
      end else begin
        chk("data_idle", kv_write.write_data, 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_wr", prev_we, 1);
        chk("sb_empty_at_done", sb_q.size(), 0);
      end
      if (error) err_cnt++;
      prev_we = kv_write.write_en;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic do_start(input logic [4:0] e, input logic [4:0] t, input logic [5:0] m);
    @(negedge clk);
    dest_entry = e; total_dwords = t; dest_valid = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dest_entry = 5'($urandom); total_dwords = 5'($urandom); dest_valid = 6'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_blk(input logic [127:0] d, input bit hold_after, input bit mid_start,
                          output bit ok);
    int n;
    n = 0;
    blk_if.blk_valid = 1'b1;
    blk_if.blk_data  = d;
    while (!blk_if.blk_ready && n < 200) begin
      start = mid_start && kv_write.write_en && !ms_done;
      if (start) begin
        ms_done = 1'b1; dest_entry = 5'h1F; total_dwords = 5'd3; dest_valid = 6'h2A;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!blk_if.blk_ready) begin
      chk("blk_timeout", n, 0);
      blk_if.blk_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold_after) blk_if.blk_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic gen_flow(input logic [4:0] e, input int t, input logic [5:0] m,
                          input bit fixed0, output logic [127:0] blks [4]);
    for (int b = 0; b < 4; b++) blks[b] = {$urandom, $urandom, $urandom, $urandom};
    if (fixed0) blks[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    for (int k = 0; k < t; k++)
      sb_q.push_back(pack_wr(e, 4'(k), m, blks[k/4][127-32*(k%4) -: 32]));
  endtask

  task automatic run_flow(input logic [4:0] e, input int t, input logic [5:0] m,
                          input bit fixed0, input bit hold, input bit mid);
    logic [127:0] blks [4];
    int d0, e0, nb, n;
    bit ok;
    d0 = done_cnt; e0 = err_cnt; ms_done = 1'b0;
    gen_flow(e, t, m, fixed0, blks);
    do_start(e, 5'(t), m);
    nb = (t + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      send_blk(blks[b], hold && (b < nb - 1), mid, ok);
      if (!ok) return;
    end
    blk_if.blk_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_pulse", done, 0);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("no_err_in_flow", err_cnt - e0, 0);
  endtask

  task automatic bad_start(input logic [4:0] t);
    int e0;
    e0 = err_cnt;
    do_start(5'd3, t, 6'h3F);
    chk("err_pulse", error, 1);
    chk("busy_err", busy, 0);
    @(negedge clk);
    chk("err_clear", error, 0);
    chk("busy_err2", busy, 0);
    #1;
    chk("err_count", err_cnt - e0, 1);
  endtask

  initial begin
    logic [127:0] blks [4];
    bit ok;
    int n;
    blk_if.blk_valid = 1'b0;
    blk_if.blk_data  = '0;

    #2;
    chk("rst_we", kv_write.write_en, 0);
    chk("rst_kv", kv_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", blk_if.blk_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_flow(5'd0, 16, 6'h3F, 1'b1, 1'b0, 1'b0);
    run_flow(5'd3, 6, 6'h05, 1'b0, 1'b0, 1'b0);
    bad_start(5'd0);
    bad_start(5'd17);
    run_flow(5'h11, 8, 6'h12, 1'b0, 1'b1, 1'b1);

    // zeroize while offset 5 of a 16-dword flow is on the port
    gen_flow(5'h07, 16, 6'h21, 1'b0, blks);
    do_start(5'h07, 5'd16, 6'h21);
    send_blk(blks[0], 1'b0, 1'b0, ok);
    blk_if.blk_valid = 1'b1;
    blk_if.blk_data  = blks[1];
    n = 0;
    while (!(kv_write.write_en && kv_write.write_offset == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("zero_reach", kv_write.write_offset, 5);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    blk_if.blk_valid = 1'b0;
    chk("zero_we", kv_write.write_en, 0);
    chk("zero_busy", busy, 0);
    chk("zero_ready", blk_if.blk_ready, 0);
    chk("zero_sb_left", sb_q.size(), 10);
    sb_q.delete();
    repeat (2) @(negedge clk);
    run_flow(5'h02, 4, 6'h3C, 1'b0, 1'b0, 1'b0);

    // reset during WRITE
    gen_flow(5'h09, 8, 6'h11, 1'b0, blks);
    do_start(5'h09, 5'd8, 6'h11);
    send_blk(blks[0], 1'b0, 1'b0, ok);
    n = 0;
    while (!(kv_write.write_en && kv_write.write_offset == 4'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach", kv_write.write_offset, 2);
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_we", kv_write.write_en, 0);
    chk("mrst_data", kv_write.write_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", blk_if.blk_ready, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", error, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    blk_if.blk_valid = 1'b1;
    blk_if.blk_data  = blks[1];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_after_rst", busy, 0);
      chk("ready_after_rst", blk_if.blk_ready, 0);
    end
    blk_if.blk_valid = 1'b0;
    run_flow(5'h0A, 5, 6'h07, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_final", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
